// File: rtl/gray_sync_capture.sv
// gray_sync_capture: synchronizes a Gray bus into clk, strobes each new value.
// Define GRAY_SYNC_ERRCNT_EN to add a saturating errCount of multi-bit steps.
module gray_sync_capture #(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] grayIn,
   output logic             outStrobe,
   output logic [WIDTH-1:0] dataOut,
   output logic             changeErr
`ifdef GRAY_SYNC_ERRCNT_EN
   ,
   output logic [15:0]      errCount
`endif
);

   localparam int CW = $clog2(SYNC_STAGES + 1);
   localparam logic [CW-1:0] FILL_LAST = CW'(SYNC_STAGES - 1);

   typedef enum logic [1:0] {
      FILL,
      PRIME,
      RUN
   } state_e;

   state_e           state, stateNext;
   logic [CW-1:0]    fillCnt, cntNext;
   logic [WIDTH-1:0] syncReg [SYNC_STAGES];
   logic [WIDTH-1:0] syncOut, lastGray, lastNext;
   logic [WIDTH-1:0] diff, dataNext;
   logic             multiBit, strobeNext, errNext;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) syncReg[i] <= '0;
      end else begin
         syncReg[0] <= grayIn;
         for (int i = 1; i < SYNC_STAGES; i++) syncReg[i] <= syncReg[i-1];
      end
   end

   assign syncOut  = syncReg[SYNC_STAGES-1];
   assign diff     = syncOut ^ lastGray;
   // clearing the lowest set bit leaves something only if >1 bit differs
   assign multiBit = (diff & (diff - WIDTH'(1))) != '0;

   always_comb begin
      stateNext  = state;
      cntNext    = fillCnt;
      strobeNext = 1'b0;
      errNext    = 1'b0;
      dataNext   = dataOut;
      lastNext   = lastGray;
      unique case (state)
         FILL: begin
            cntNext = fillCnt + CW'(1);
            if (fillCnt == FILL_LAST) stateNext = PRIME;
         end
         PRIME: begin
            strobeNext = 1'b1;
            dataNext   = syncOut;
            lastNext   = syncOut;
            stateNext  = RUN;
         end
         RUN: begin
            if (diff != '0) begin
               strobeNext = 1'b1;
               dataNext   = syncOut;
               lastNext   = syncOut;
               errNext    = multiBit;
            end
         end
         default: stateNext = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FILL;
         fillCnt   <= '0;
         outStrobe <= 1'b0;
         changeErr <= 1'b0;
         dataOut   <= '0;
         lastGray  <= '0;
      end else begin
         state     <= stateNext;
         fillCnt   <= cntNext;
         outStrobe <= strobeNext;
         changeErr <= errNext;
         dataOut   <= dataNext;
         lastGray  <= lastNext;
      end
   end

`ifdef GRAY_SYNC_ERRCNT_EN
   always_ff @(posedge clk) begin
      if (rst)
         errCount <= '0;
      else if (errNext && errCount != 16'hFFFF)
         errCount <= errCount + 16'd1;
   end
`endif

endmodule
